// File: rtl/decode_ctrl_pipe_if.sv
// rtl/decode_ctrl_pipe_if.sv - instruction handoff bus into the decode control pipe
//
// in_valid : instr holds a fetched instruction
// instr    : 32-bit instruction word
// in_ready : consumer accepts instr this cycle when in_valid is high
interface decode_ctrl_pipe_if;
    logic        in_valid;
    logic [31:0] instr;
    logic        in_ready;

    modport master (output in_valid, output instr, input in_ready);
    modport slave  (input in_valid, input instr, output in_ready);
endinterface

// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - MIPS-style decoder with load-use interlock and control pipeline
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_if (slave)       in_valid/instr in, in_ready out
//   stall_i             hold every stage register and bubble_cnt
//   flush_i             squash the instruction currently presented
//   ex_*                stage-1 fields, zero when ex_valid is 0
//   mem_*               stage STAGES-1 fields, zero when mem_valid is 0
//   wb_*                stage STAGES fields, zero when wb_valid is 0
//   exc_o               illegal instruction in stage 1
//   bubble_cnt          saturating count of load-use bubbles
module decode_ctrl_pipe #(
    parameter int STAGES  = 3,
    parameter bit COP0_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_ctrl_pipe_if.slave   in_if,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                ex_valid,
    output logic [2:0]          ex_alusrcb,
    output logic                ex_pcplus8,
    output logic [3:0]          ex_jb,
    output logic                mem_valid,
    output logic [2:0]          mem_ldst,
    output logic                mem_memtoreg,
    output logic                wb_valid,
    output logic                wb_regwrite,
    output logic [4:0]          wb_dest,
    output logic                exc_o,
    output logic [15:0]         bubble_cnt
);
    if (STAGES < 3 || STAGES > 5) begin : g_bad_stages
        $error("decode_ctrl_pipe: STAGES must be 3..5");
    end

    localparam logic [3:0] JB_J    = 4'b0001, JB_JR   = 4'b0010, JB_BEQ  = 4'b0011,
                           JB_BNE  = 4'b0100, JB_BLEZ = 4'b0101, JB_BGTZ = 4'b0110,
                           JB_BLTZ = 4'b0111, JB_BGEZ = 4'b1000;
    localparam logic [2:0] ASRC_RT   = 3'b000, ASRC_SEXT = 3'b010, ASRC_ZEXT = 3'b011,
                           ASRC_ZERO = 3'b100, ASRC_SHAMT = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic [2:0] ldst;
        logic [3:0] jb;
        logic [2:0] alusrcb;
        logic       pcplus8;
        logic [4:0] dest;
        logic       illegal;
    } ctrl_t;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    ctrl_t      dec;
    logic       rs_used, rt_used, hazard;
    ctrl_t      stage_q [1:STAGES];
    ctrl_t      s_ex, s_mem, s_wb;

    assign op    = in_if.instr[31:26];
    assign rs    = in_if.instr[25:21];
    assign rt    = in_if.instr[20:16];
    assign rd    = in_if.instr[15:11];
    assign funct = in_if.instr[5:0];

    always_comb begin
        dec     = '0;
        rs_used = 1'b1;
        rt_used = 1'b0;
        case (op)
            6'h00: begin
                dec.regwrite = 1'b1;
                dec.dest     = rd;
                rt_used      = 1'b1;
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        dec.alusrcb = ASRC_SHAMT;
                        rs_used     = 1'b0;
                    end
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        dec.alusrcb = ASRC_RT;
                    end
                    6'h08: begin
                        dec.jb       = JB_JR;
                        dec.regwrite = 1'b0;
                    end
                    6'h09: begin
                        dec.jb      = JB_JR;
                        dec.pcplus8 = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h01: begin
                dec.alusrcb = ASRC_ZERO;
                if (rt == 5'd0)      dec.jb = JB_BLTZ;
                else if (rt == 5'd1) dec.jb = JB_BGEZ;
                else                 dec.illegal = 1'b1;
            end
            6'h02: begin
                dec.jb  = JB_J;
                rs_used = 1'b0;
            end
            6'h03: begin
                dec.jb       = JB_J;
                dec.pcplus8  = 1'b1;
                dec.regwrite = 1'b1;
                dec.dest     = 5'd31;
                rs_used      = 1'b0;
            end
            6'h04: begin dec.jb = JB_BEQ;  rt_used = 1'b1; end
            6'h05: begin dec.jb = JB_BNE;  rt_used = 1'b1; end
            6'h06: begin dec.jb = JB_BLEZ; dec.alusrcb = ASRC_ZERO; end
            6'h07: begin dec.jb = JB_BGTZ; dec.alusrcb = ASRC_ZERO; end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                dec.alusrcb  = ASRC_SEXT;
                dec.regwrite = 1'b1;
                dec.dest     = rt;
            end
            6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                dec.alusrcb  = ASRC_ZEXT;
                dec.regwrite = 1'b1;
                dec.dest     = rt;
                rs_used      = (op != 6'h0f);
            end
            6'h10: begin
                if (COP0_EN && rs == 5'd0) begin
                    dec.regwrite = 1'b1;
                    dec.dest     = rt;
                end else if (COP0_EN && rs == 5'd4) begin
                    rt_used = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.dest     = rt;
                dec.alusrcb  = ASRC_SEXT;
                case (op[2:0])
                    3'd0:    dec.ldst = 3'b000;
                    3'd1:    dec.ldst = 3'b001;
                    3'd3:    dec.ldst = 3'b010;
                    3'd4:    dec.ldst = 3'b011;
                    default: dec.ldst = 3'b100;
                endcase
            end
            6'h28, 6'h29, 6'h2b: begin
                dec.alusrcb = ASRC_SEXT;
                rt_used     = 1'b1;
                case (op[1:0])
                    2'd0:    dec.ldst = 3'b101;
                    2'd1:    dec.ldst = 3'b110;
                    default: dec.ldst = 3'b111;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings carry no side effects: every control field cleared.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        if (dec.dest == 5'd0) dec.regwrite = 1'b0;
        dec.valid = 1'b1;
    end

    assign s_ex  = stage_q[1];
    assign s_mem = stage_q[STAGES-1];
    assign s_wb  = stage_q[STAGES];

    // Load in EX whose result the presented instruction needs: insert a bubble.
    assign hazard = in_if.in_valid & s_ex.valid & s_ex.memtoreg & (s_ex.dest != 5'd0) &
                    ((rs_used & (rs == s_ex.dest)) | (rt_used & (rt == s_ex.dest)));

    assign in_if.in_ready = ~stall_i & ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= STAGES; k++) stage_q[k] <= '0;
            bubble_cnt <= '0;
        end else if (!stall_i) begin
            for (int k = STAGES; k >= 2; k--) stage_q[k] <= stage_q[k-1];
            stage_q[1] <= (!flush_i && !hazard && in_if.in_valid) ? dec : '0;
            if (hazard && !flush_i && bubble_cnt != 16'hffff)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign ex_valid     = s_ex.valid;
    assign ex_alusrcb   = s_ex.valid  ? s_ex.alusrcb  : 3'b000;
    assign ex_pcplus8   = s_ex.valid  & s_ex.pcplus8;
    assign ex_jb        = s_ex.valid  ? s_ex.jb       : 4'b0000;
    assign exc_o        = s_ex.valid  & s_ex.illegal;
    assign mem_valid    = s_mem.valid;
    assign mem_ldst     = s_mem.valid ? s_mem.ldst    : 3'b000;
    assign mem_memtoreg = s_mem.valid & s_mem.memtoreg;
    assign wb_valid     = s_wb.valid;
    assign wb_regwrite  = s_wb.valid  & s_wb.regwrite;
    assign wb_dest      = s_wb.valid  ? s_wb.dest     : 5'd0;
endmodule
